// File: rtl/serial_load_counter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : slc_pkg                                                    |
// | Description : Shared types and constants for serial_load_counter.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package slc_pkg;

  // Default width of the serial count field and down-counter.
  localparam int unsigned C_CNT_W_DEFAULT = 4;

  // FSM encoding; values are fixed so the detector side can decode them.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    COUNT = 2'b10,
    DONE  = 2'b11
  } slc_state_t;

endpackage
`default_nettype wire

// File: rtl/slc_shift_down_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : slc_shift_down_counter                                     |
// | Description : CNT_W-bit register that shifts in a serial field MSB first |
// |               and then counts down to zero without wrapping.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module slc_shift_down_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             dec_en,
  input  logic             clr,
  input  logic             serial_in,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  assign value = value_q;
  assign zero  = (value_q == '0);

  // Next value: clear beats shift beats decrement; decrement saturates at 0.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (shift_en) begin
      value_d = {value_q[CNT_W-2:0], serial_in};
    end else if (dec_en && !zero) begin
      value_d = value_q - CNT_W'(1);
    end
  end

  // Value register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_load_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_load_counter                                        |
// | Description : On the detector's wait flag, loads a CNT_W-bit count from  |
// |               the serial line, counts it down to zero and then emits a   |
// |               one-cycle release pulse on cntrl.                          |
// | Options     : SLC_PAUSE_EN - adds a pause input that freezes COUNT.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_load_counter
  import slc_pkg::*;
#(
  parameter int unsigned CNT_W = C_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic             j,
`ifdef SLC_PAUSE_EN
  input  logic             pause,
`endif
  output logic             cntrl,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned       c_idx_w    = $clog2(CNT_W);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(CNT_W - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  slc_state_t         state_q;
  slc_state_t         state_d;
  logic [c_idx_w-1:0] idx_q;
  logic [c_idx_w-1:0] idx_d;

  logic shift_en;
  logic dec_en;
  logic clr;
  logic zero;
  logic hold;

`ifdef SLC_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  slc_shift_down_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .dec_en    (dec_en),
    .clr       (clr),
    .serial_in (j),
    .value     (count),
    .zero      (zero)
  );

  // Outputs decode the state register only, so no input reaches them.
  assign cntrl = (state_q == DONE);
  assign busy  = (state_q != IDLE);

  // Next-state, load-index and counter-control decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_en = 1'b0;
    dec_en   = 1'b0;
    clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (w) begin
          shift_en = 1'b1;
          idx_d    = c_idx_one;
          state_d  = LOAD;
        end else begin
          clr   = 1'b1;
          idx_d = '0;
        end
      end
      LOAD: begin
        if (!w) begin
          clr     = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          shift_en = 1'b1;
          idx_d    = idx_q + c_idx_one;
          if (idx_q == c_idx_last) begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        // Abort wins over pause; pause freezes both state and count.
        if (!w) begin
          clr     = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else if (hold) begin
          state_d = COUNT;
        end else if (zero) begin
          state_d = DONE;
        end else begin
          dec_en = 1'b1;
        end
      end
      DONE: begin
        // w is ignored here: the detector drops it on this same edge.
        state_d = IDLE;
      end
      default: begin
        clr     = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and index registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_load_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_load_counter                                     |
// | Description : Directed self-checking bench for serial_load_counter       |
// |               (CNT_W=4). Pause cases run only with SLC_PAUSE_EN.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_load_counter;

  logic       clk;
  logic       rst;
  logic       w;
  logic       j;
`ifdef SLC_PAUSE_EN
  logic       pause;
`endif
  logic       cntrl;
  logic       busy;
  logic [3:0] count;

  int n_checks;
  int n_errors;

  int cnt_log  [0:31];
  int busy_log [0:31];
  int first_c;
  int n_c;

  serial_load_counter #(
    .CNT_W (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .w     (w),
    .j     (j),
`ifdef SLC_PAUSE_EN
    .pause (pause),
`endif
    .cntrl (cntrl),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; returns 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the first cycle with w=1. The field is driven MSB first on
  // cycles 0..3. w drops at abort_cyc (if >= 0) or the cycle after cntrl.
  task automatic run_field(input logic [3:0] field, input int abort_cyc,
                           input int p_lo, input int p_hi, input int max_cyc);
    first_c = -1;
    n_c     = 0;
    for (int c = 0; c <= max_cyc; c++) begin
      cnt_log[c]  = int'(count);
      busy_log[c] = int'(busy);
      if (cntrl) begin
        if (first_c < 0) first_c = c;
        n_c++;
      end
      if (abort_cyc >= 0 && c >= abort_cyc) w = 1'b0;
      else if (first_c >= 0 && c > first_c) w = 1'b0;
      else w = 1'b1;
      j = (c < 4) ? field[3-c] : 1'b1;
`ifdef SLC_PAUSE_EN
      pause = (c >= p_lo && c <= p_hi);
`endif
      tick();
    end
`ifdef SLC_PAUSE_EN
    pause = 1'b0;
`endif
  endtask

  task automatic settle_idle();
    w = 1'b0;
    j = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    w   = 1'b0;
    j   = 1'b0;
`ifdef SLC_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (2) tick();
    check("por_busy",  int'(busy),  0);
    check("por_cntrl", int'(cntrl), 0);
    check("por_count", int'(count), 0);
    rst = 1'b0;
    tick();

    // Nominal: detector preamble 1,0,1,1,0 then field 0011 = 3.
    for (int k = 0; k < 5; k++) begin
      j = (k == 1 || k == 4) ? 1'b0 : 1'b1;
      tick();
    end
    run_field(4'd3, -1, 99, 99, 11);
    check("nom_busy_c0",  busy_log[0], 0);
    check("nom_busy_c1",  busy_log[1], 1);
    check("nom_load_c3",  cnt_log[3],  1);
    check("nom_count_c4", cnt_log[4],  3);
    check("nom_count_c8", cnt_log[8],  0);
    check("nom_cntrl_at", first_c,     8);
    check("nom_pulses",   n_c,         1);
    check("nom_busy_c9",  busy_log[9], 0);
    settle_idle();

    // Zero field: one COUNT cycle, release at cycle 5, no wrap.
    run_field(4'd0, -1, 99, 99, 8);
    check("zero_count_c4", cnt_log[4],  0);
    check("zero_cntrl_at", first_c,     5);
    check("zero_pulses",   n_c,         1);
    check("zero_count_c5", cnt_log[5],  0);
    check("zero_busy_c6",  busy_log[6], 0);
    settle_idle();

    // Max field: 15 -> release at cycle 20.
    run_field(4'd15, -1, 99, 99, 23);
    check("max_count_c4",  cnt_log[4],  15);
    check("max_count_c19", cnt_log[19], 0);
    check("max_cntrl_at",  first_c,     20);
    check("max_pulses",    n_c,         1);
    settle_idle();

    // Abort during COUNT at cycle 6.
    run_field(4'd3, 6, 99, 99, 12);
    check("abc_busy_c6",  busy_log[6], 1);
    check("abc_count_c6", cnt_log[6],  1);
    check("abc_busy_c7",  busy_log[7], 0);
    check("abc_count_c7", cnt_log[7],  0);
    check("abc_pulses",   n_c,         0);
    settle_idle();

    // Abort during LOAD at cycle 2.
    run_field(4'd15, 2, 99, 99, 10);
    check("abl_busy_c2",  busy_log[2], 1);
    check("abl_count_c2", cnt_log[2],  3);
    check("abl_busy_c3",  busy_log[3], 0);
    check("abl_count_c3", cnt_log[3],  0);
    check("abl_pulses",   n_c,         0);
    settle_idle();

`ifdef SLC_PAUSE_EN
    // Pause cycles 5-6 with field 3: count frozen at 2, release at 10.
    run_field(4'd3, -1, 5, 6, 13);
    check("pz_count_c5", cnt_log[5], 2);
    check("pz_count_c6", cnt_log[6], 2);
    check("pz_count_c7", cnt_log[7], 2);
    check("pz_count_c8", cnt_log[8], 1);
    check("pz_cntrl_at", first_c,    10);
    check("pz_pulses",   n_c,        1);
    settle_idle();
`endif

    // Reset mid-COUNT (field 15, cycle 9 -> count 10), held for 2 cycles.
    run_field(4'd15, -1, 99, 99, 8);
    check("rst_pre_busy",  int'(busy),  1);
    check("rst_pre_count", int'(count), 10);
    rst = 1'b1;
    tick();
    check("rst_e1_busy",  int'(busy),  0);
    check("rst_e1_count", int'(count), 0);
    check("rst_e1_cntrl", int'(cntrl), 0);
    tick();
    check("rst_e2_busy",  int'(busy),  0);
    rst = 1'b0;
    w   = 1'b0;
    repeat (25) begin
      tick();
      check("rst_no_cntrl", int'(cntrl), 0);
      if (cntrl) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
